// File: rtl/rv32i_types.sv
// Shared types and helpers for the RV32I pipeline front end.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction addresses are word-aligned; low bits of any target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_buf.sv
// One-entry IF/ID output buffer: clear beats load, load beats consume.
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic        i_consume,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Buffer entry update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, redirect/squash handling,
// result parked in a one-entry buffer feeding the IF/ID latch.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic         r_imem_read;

    logic         w_buf_valid;
    logic         w_buf_free;
    logic         w_fill;
    logic [31:0]  w_redirect_target;

    assign w_redirect_target = align_pc(redirect_pc);
    assign w_buf_free        = ~w_buf_valid | advance;
    assign w_fill            = (r_state == REQ) & imem_resp & ~redirect;

    // Request FSM, PC and request-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_imem_read <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                    end else if (w_buf_free) begin
                        r_req_addr  <= r_pc;
                        r_imem_read <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                        if (imem_resp) begin
                            r_imem_read <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_state <= SQUASH;
                        end
                    end else if (imem_resp) begin
                        r_pc        <= r_req_addr + PC_STEP;
                        r_imem_read <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                SQUASH: begin
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                    end
                    // The stale response must still be absorbed before the bus is free.
                    if (imem_resp) begin
                        r_imem_read <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_imem_read <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign imem_read    = r_imem_read;
    assign imem_address = r_req_addr;

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_fill),
        .i_clear   (redirect),
        .i_consume (advance),
        .i_instr   (imem_rdata),
        .i_pc      (r_req_addr),
        .o_valid   (w_buf_valid),
        .o_instr   (instr_out),
        .o_pc      (pc_out)
    );

    assign valid_out = w_buf_valid;

endmodule
